// File: rtl/enclave_bus_arbiter.sv
// rtl/enclave_bus_arbiter.sv - round-robin Wishbone/LA arbiter for one shared resource with bounded-latency timeout
module enclave_bus_arbiter #(
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] BASE    = 32'h3000_0000,
    parameter int          TIMEOUT = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_addr_i,
    input  logic [31:0]       la_wdata_i,
    output logic              la_ack_o,
    output logic [31:0]       la_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam logic [7:0]  TIMEOUT_CNT  = 8'(TIMEOUT);

    state_t      state;
    logic        last_la;
    logic        gnt_la;
    logic [7:0]  xfer_cnt;

    logic        wb_hit;
    logic        la_hit;
    logic        pick_la;
    logic        xfer_done;
    logic [31:0] resp_data;
    logic        unused_adr_lsb;

    // Byte-lane bits of the Wishbone address carry no meaning for a word resource.
    assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

    assign wb_hit = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign la_hit = la_req_i;

    always_comb begin
        pick_la = la_hit;
        if (wb_hit && la_hit) begin
            pick_la = ~last_la;
        end
    end

    // An ack in the final counted cycle still wins over the timeout.
    assign xfer_done = mem_ack_i || (xfer_cnt == TIMEOUT_CNT);

    always_comb begin
        resp_data = TIMEOUT_DATA;
        if (mem_ack_i) begin
            resp_data = mem_we_o ? 32'h0 : mem_rdata_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            last_la     <= 1'b1;
            gnt_la      <= 1'b0;
            xfer_cnt    <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'h0;
            mem_wstrb_o <= 4'h0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0;
            la_ack_o    <= 1'b0;
            la_rdata_o  <= 32'h0;
            timeout_o   <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            la_ack_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_hit || la_hit) begin
                        state     <= XFER;
                        gnt_la    <= pick_la;
                        last_la   <= pick_la;
                        xfer_cnt  <= 8'd0;
                        mem_req_o <= 1'b1;
                        if (pick_la) begin
                            mem_we_o    <= la_we_i;
                            mem_addr_o  <= la_addr_i;
                            mem_wdata_o <= la_wdata_i;
                            mem_wstrb_o <= 4'hF;
                        end else begin
                            mem_we_o    <= wbs_we_i;
                            mem_addr_o  <= wbs_adr_i[ADDR_W+1:2];
                            mem_wdata_o <= wbs_dat_i;
                            mem_wstrb_o <= wbs_sel_i;
                        end
                    end
                end
                XFER: begin
                    if (xfer_done) begin
                        state     <= RESP;
                        mem_req_o <= 1'b0;
                        if (!mem_ack_i) begin
                            timeout_o <= 1'b1;
                        end
                        // Ack and data are registered here so they are visible during RESP.
                        if (gnt_la) begin
                            la_ack_o   <= 1'b1;
                            la_rdata_o <= resp_data;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= resp_data;
                        end
                    end else begin
                        xfer_cnt <= xfer_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
